// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C init-table sequencer.
// Imported by the sequencer top and its millisecond timer.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    FINISH,
    FAIL
  } state_e;

  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [7:0]  DLY_OP   = 8'hFE;
  localparam int STROBES_PER_MS_DEF = 100;

endpackage

// File: rtl/i2c_ms_timer.sv
// Divides strobe ticks into milliseconds and counts a loaded
// millisecond budget down to zero.
module i2c_ms_timer
  import i2c_pkg::*;
#(
  parameter int SPM = STROBES_PER_MS_DEF
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       strobe,
  output logic       expired
);

  localparam int SW = (SPM > 1) ? $clog2(SPM) : 1;

  logic [SW-1:0] sub_q, sub_d;
  logic [7:0]    ms_q, ms_d;

  always_comb begin
    sub_d = sub_q;
    ms_d  = ms_q;
    if (load) begin
      ms_d  = value;
      sub_d = '0;
    end else if (strobe && ms_q != 8'd0) begin
      if (sub_q == SW'(SPM - 1)) begin
        sub_d = '0;
        ms_d  = ms_q - 8'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sub_q <= '0;
      ms_q  <= '0;
    end else begin
      sub_q <= sub_d;
      ms_q  <= ms_d;
    end
  end

  assign expired = (ms_q == 8'd0);

endmodule

// File: rtl/i2c_init_seq.sv
// Walks an init table, issuing register words to an I2C controller
// with NACK retry, millisecond delay entries and an end marker.
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int DEPTH          = 65,
  parameter int ADDR_W         = 7,
  parameter int MAX_RETRY      = 3,
  parameter int STROBES_PER_MS = STROBES_PER_MS_DEF
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              strobe_100kHz,
  input  logic              start,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [15:0]       cmd_data,
  input  logic              ctrl_done,
  input  logic              ctrl_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              rd_q, done_q, done_d;
  logic              err_q, err_d, busy_q;
  logic              adv, tmr_load, tmr_exp;

  i2c_ms_timer #(.SPM(STROBES_PER_MS)) u_tmr (
    .clk      (clk),
    .areset_n (areset_n),
    .load     (tmr_load),
    .value    (rom_data[7:0]),
    .strobe   (strobe_100kHz && state_q == DELAY),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    fail_d   = fail_q;
    done_d   = done_q;
    err_d    = err_q;
    adv      = 1'b0;
    tmr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (rom_data == END_MARK): state_d = FINISH;
          (rom_data[15:8] == DLY_OP): begin
            if (rom_data[7:0] == 8'd0) begin
              adv = 1'b1;
            end else begin
              tmr_load = 1'b1;
              state_d  = DELAY;
            end
          end
          default: begin
            cmd_d   = rom_data;
            state_d = ISSUE;
          end
        endcase
      end
      ISSUE: begin
        if (cmd_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ctrl_done && !ctrl_nack) begin
          retry_d = '0;
          adv     = 1'b1;
        end else if (ctrl_done) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end else begin
            fail_d  = idx_q;
            err_d   = 1'b1;
            state_d = FAIL;
          end
        end
      end
      DELAY: begin
        if (tmr_exp) adv = 1'b1;
      end
      FINISH: state_d = IDLE;
      FAIL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The index saturates at DEPTH: reaching it ends the table.
    if (adv) begin
      idx_d   = idx_q + 1'b1;
      state_d = (idx_d == ADDR_W'(DEPTH)) ? FINISH : FETCH;
    end
    if (state_d == FINISH) done_d = 1'b1;
    if (state_d == FETCH) addr_d = idx_d;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      fail_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      fail_q  <= fail_d;
      rd_q    <= (state_d == FETCH);
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign rom_rd    = rd_q;
  assign rom_addr  = addr_q;
  assign cmd_valid = (state_q == ISSUE);
  assign cmd_data  = cmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: command words go through a
// scoreboard queue, status is checked after each sequence.
module tb_i2c_init_seq;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        strobe_100kHz = 1'b0;
  logic        start = 1'b0;
  logic        rom_rd;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [15:0] cmd_data;
  logic        ctrl_done = 1'b0;
  logic        ctrl_nack = 1'b0;
  logic        busy, done, error;
  logic [6:0]  fail_addr;

  i2c_init_seq dut (
    .clk           (clk),
    .areset_n      (areset_n),
    .strobe_100kHz (strobe_100kHz),
    .start         (start),
    .rom_rd        (rom_rd),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .ctrl_done     (ctrl_done),
    .ctrl_nack     (ctrl_nack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .fail_addr     (fail_addr)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [128];
  logic [15:0] expq [$];
  bit          nackq [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          fetch_cnt = 0;
  logic [6:0]  last_addr = '0;
  int          cyc = 0;

  always @(posedge clk) begin
    if (rom_rd) rom_data <= mem[rom_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One strobe every 10 cycles, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      strobe_100kHz = (cyc % 10 == 0);
    end
  end

  // Controller model: always ready, done one cycle after handshake.
  initial begin
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      ctrl_done = 1'b0;
      ctrl_nack = 1'b0;
      if (pend) begin
        ctrl_done = 1'b1;
        ctrl_nack = (nackq.size() > 0) ? nackq.pop_front() : 1'b0;
        pend = 1'b0;
      end
      if (cmd_valid && cmd_ready && areset_n) pend = 1'b1;
    end
  end

  // Scoreboard monitor and fetch tracker.
  initial begin
    forever begin
      @(negedge clk);
      if (rom_rd) begin
        fetch_cnt++;
        last_addr = rom_addr;
      end
      if (cmd_valid && cmd_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_cmd", {16'h0, cmd_data}, 32'hFFFF_FFFF);
        end else begin
          chk("cmd_data", {16'h0, cmd_data}, {16'h0, expq.pop_front()});
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) @(negedge clk);
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_fetch(input logic [6:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rom_rd && rom_addr == a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rom_rd"}, {31'h0, rom_rd}, 32'h0);
    chk({tag, "_rom_addr"}, {25'h0, rom_addr}, 32'h0);
    chk({tag, "_cmd_valid"}, {31'h0, cmd_valid}, 32'h0);
    chk({tag, "_cmd_data"}, {16'h0, cmd_data}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_error"}, {31'h0, error}, 32'h0);
    chk({tag, "_fail_addr"}, {25'h0, fail_addr}, 32'h0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
  endtask

  initial begin
    int f0, cnt;
    bit ok;

    clear_mem();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    areset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two plain register writes then the end marker.
    clear_mem();
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
    expq.push_back(16'h1234); expq.push_back(16'h5678);
    do_start();
    wait_idle(500);
    chk("t1_done", {31'h0, done}, 32'h1);
    chk("t1_busy", {31'h0, busy}, 32'h0);
    chk("t1_error", {31'h0, error}, 32'h0);
    chk("t1_left", expq.size(), 32'd0);

    // 2 ms delay entry: 200 strobes between decode and next issue.
    clear_mem();
    mem[0] = 16'hFE02; mem[1] = 16'h0042; mem[2] = 16'hFFFF;
    expq.push_back(16'h0042);
    do_start();
    wait_fetch(7'd0, ok);
    chk("t2_fetch0", {31'h0, ok}, 32'h1);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cmd_valid) break;
      if (strobe_100kHz) cnt++;
    end
    chk("t2_cmd_seen", {31'h0, cmd_valid}, 32'h1);
    chk("t2_dly_min", {31'h0, cnt >= 200}, 32'h1);
    chk("t2_dly_max", {31'h0, cnt <= 201}, 32'h1);
    wait_idle(500);
    chk("t2_done", {31'h0, done}, 32'h1);
    chk("t2_left", expq.size(), 32'd0);

    // Three NACKs then ACK on one entry.
    clear_mem();
    mem[0] = 16'h00AA; mem[1] = 16'hFFFF;
    repeat (4) expq.push_back(16'h00AA);
    nackq = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_start();
    wait_idle(500);
    chk("t3_done", {31'h0, done}, 32'h1);
    chk("t3_error", {31'h0, error}, 32'h0);
    chk("t3_left", expq.size(), 32'd0);

    // Entry 5 NACKed four times aborts the sequence.
    clear_mem();
    for (int i = 0; i < 5; i++) begin
      mem[i] = 16'h0100 + 16'(i);
      expq.push_back(16'h0100 + 16'(i));
      nackq.push_back(1'b0);
    end
    mem[5] = 16'h0555; mem[6] = 16'h0666;
    repeat (4) begin
      expq.push_back(16'h0555);
      nackq.push_back(1'b1);
    end
    f0 = fetch_cnt;
    do_start();
    wait_idle(1000);
    chk("t4_error", {31'h0, error}, 32'h1);
    chk("t4_fail_addr", {25'h0, fail_addr}, 32'd5);
    chk("t4_done", {31'h0, done}, 32'h0);
    chk("t4_fetches", fetch_cnt - f0, 32'd6);
    repeat (30) @(negedge clk);
    chk("t4_no_more_rd", fetch_cnt - f0, 32'd6);
    chk("t4_left", expq.size(), 32'd0);

    // Full table without end marker stops at DEPTH.
    clear_mem();
    for (int i = 0; i < 65; i++) begin
      mem[i] = 16'h2000 + 16'(i);
      expq.push_back(16'h2000 + 16'(i));
    end
    f0 = fetch_cnt;
    do_start();
    wait_idle(2000);
    chk("t5_fetches", fetch_cnt - f0, 32'd65);
    chk("t5_last_addr", {25'h0, last_addr}, 32'd64);
    chk("t5_index", {25'h0, dut.idx_q}, 32'd65);
    chk("t5_done", {31'h0, done}, 32'h1);
    chk("t5_left", expq.size(), 32'd0);

    // Reset during a delay aborts; a new start replays from index 0.
    clear_mem();
    mem[0] = 16'h0011; mem[1] = 16'hFE01;
    mem[2] = 16'h0022; mem[3] = 16'hFFFF;
    expq.push_back(16'h0011);
    do_start();
    wait_fetch(7'd1, ok);
    chk("t6_fetch1", {31'h0, ok}, 32'h1);
    repeat (20) @(negedge clk);
    areset_n = 1'b0;
    @(negedge clk);
    chk_zero("t6_rst");
    @(negedge clk);
    areset_n = 1'b1;
    f0 = fetch_cnt;
    repeat (50) @(negedge clk);
    chk("t6_no_resume_busy", {31'h0, busy}, 32'h0);
    chk("t6_no_resume_rd", fetch_cnt - f0, 32'd0);
    expq.push_back(16'h0011); expq.push_back(16'h0022);
    do_start();
    wait_fetch(7'd0, ok);
    chk("t6_replay0", {31'h0, ok}, 32'h1);
    wait_idle(5000);
    chk("t6_done", {31'h0, done}, 32'h1);
    chk("t6_left", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
